// File: rtl/tcam_axis_stream.sv
// TCAM with AXI4-Stream command/response framing: write, lookup, invalidate,
// clear-all commands in; one 2-beat status/data response out per command.

// One TCAM entry compare: masked key equality gated by the entry's valid bit.
module tcam_match_cell #(
  parameter int KEY_WIDTH = 32
) (
  input  logic                 vld,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [KEY_WIDTH-1:0] ent_key,
  input  logic [KEY_WIDTH-1:0] ent_mask,
  output logic                 hit
);
  assign hit = vld && (((key ^ ent_key) & ~ent_mask) == '0);
endmodule

module tcam_axis_stream #(
  parameter int TDATA_WIDTH = 32,
  parameter int KEY_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                     S_AXIS_TLAST,
  input  logic                     S_AXIS_TVALID,
  output logic                     S_AXIS_TREADY,
  output logic [TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                     M_AXIS_TLAST,
  output logic                     M_AXIS_TVALID,
  input  logic                     M_AXIS_TREADY
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] OP_WRITE = 4'd1, OP_LOOKUP = 4'd2, OP_INVAL = 4'd3, OP_CLEAR = 4'd4;

  typedef enum logic [2:0] {HDR, COLLECT, DRAIN, EXEC, ENC, RESP0, RESP1} state_t;

  state_t                  state, state_nxt;
  logic                    err_len, err_op, err_len_nxt, err_op_nxt;
  logic                    rst_done;
  logic [3:0]              op;
  logic [7:0]              tag;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [1:0]              bidx;
  logic [KEY_WIDTH-1:0]    key_r, mask_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [KEY_WIDTH-1:0]    key_mem  [DEPTH];
  logic [KEY_WIDTH-1:0]    mask_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem [DEPTH];
  logic [DEPTH-1:0]        valid, match_c, match_q;
  logic [ADDR_WIDTH-1:0]   idx_c, idx_q;
  logic                    hit_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [TDATA_WIDTH-1:0]  m_tdata;

  // Strobes carry no meaning here; header/payload bits outside the fields are ignored.
  logic unused_in;
  assign unused_in = ^{S_AXIS_TSTRB, S_AXIS_TDATA};

  logic       s_fire, h_known, h_multi, fin, op_ok;
  logic [3:0] h_op;
  assign s_fire  = S_AXIS_TVALID && S_AXIS_TREADY;
  assign h_op    = S_AXIS_TDATA[3:0];
  assign h_known = (h_op >= OP_WRITE) && (h_op <= OP_CLEAR);
  assign h_multi = (h_op == OP_WRITE) || (h_op == OP_LOOKUP);
  assign fin     = (op == OP_WRITE) ? (bidx == 2'd3) : (bidx == 2'd1);
  assign op_ok   = !err_len && !err_op;

  // Per-entry compare array against the latched lookup key.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    tcam_match_cell #(.KEY_WIDTH(KEY_WIDTH)) u_cell (
      .vld      (valid[g]),
      .key      (key_r),
      .ent_key  (key_mem[g]),
      .ent_mask (mask_mem[g]),
      .hit      (match_c[g])
    );
  end

  // State register and error flags; rst_done keeps TREADY low for one cycle after reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= HDR;
      err_len  <= 1'b0;
      err_op   <= 1'b0;
      rst_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_len  <= err_len_nxt;
      err_op   <= err_op_nxt;
      rst_done <= 1'b1;
    end
  end

  // Frame parsing and response sequencing.
  always_comb begin
    state_nxt   = state;
    err_len_nxt = err_len;
    err_op_nxt  = err_op;
    case (state)
      HDR: if (s_fire) begin
        err_len_nxt = 1'b0;
        err_op_nxt  = !h_known;
        if (!h_known) state_nxt = S_AXIS_TLAST ? EXEC : DRAIN;
        else if (h_multi) begin
          if (S_AXIS_TLAST) begin err_len_nxt = 1'b1; state_nxt = EXEC; end
          else state_nxt = COLLECT;
        end else begin
          if (S_AXIS_TLAST) state_nxt = EXEC;
          else begin err_len_nxt = 1'b1; state_nxt = DRAIN; end
        end
      end
      COLLECT: if (s_fire) begin
        if (fin) begin
          state_nxt = S_AXIS_TLAST ? EXEC : DRAIN;
          if (!S_AXIS_TLAST) err_len_nxt = 1'b1;
        end else if (S_AXIS_TLAST) begin
          err_len_nxt = 1'b1;
          state_nxt   = EXEC;
        end
      end
      DRAIN:   if (s_fire && S_AXIS_TLAST) state_nxt = EXEC;
      EXEC:    state_nxt = ENC;
      ENC:     state_nxt = RESP0;
      RESP0:   if (M_AXIS_TREADY) state_nxt = RESP1;
      RESP1:   if (M_AXIS_TREADY) state_nxt = HDR;
      default: state_nxt = HDR;
    endcase
  end

  // Field capture, valid-bit maintenance, match vector and encode stage.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      valid   <= '0;
      match_q <= '0;
    end else begin
      if (state == HDR && s_fire) begin
        op   <= h_op;
        tag  <= S_AXIS_TDATA[15:8];
        addr <= S_AXIS_TDATA[16 +: ADDR_WIDTH];
        bidx <= 2'd1;
      end
      if (state == COLLECT && s_fire) begin
        case (bidx)
          2'd1:    key_r  <= S_AXIS_TDATA[KEY_WIDTH-1:0];
          2'd2:    mask_r <= S_AXIS_TDATA[KEY_WIDTH-1:0];
          default: data_r <= S_AXIS_TDATA[DATA_WIDTH-1:0];
        endcase
        bidx <= bidx + 2'd1;
      end
      if (state == EXEC) begin
        match_q <= (op == OP_LOOKUP && op_ok) ? match_c : '0;
        if (op_ok) begin
          case (op)
            OP_WRITE: valid[addr] <= 1'b1;
            OP_INVAL: valid[addr] <= 1'b0;
            OP_CLEAR: valid       <= '0;
            default:  ;
          endcase
        end
      end
      if (state == ENC) begin
        hit_q   <= |match_q;
        idx_q   <= idx_c;
        rdata_q <= data_mem[idx_c];
      end
    end
  end

  // Entry storage is not reset; writes are blocked while reset is asserted.
  always_ff @(posedge ACLK) begin
    if (!ARESET && state == EXEC && op == OP_WRITE && op_ok) begin
      key_mem[addr]  <= key_r;
      mask_mem[addr] <= mask_r;
      data_mem[addr] <= data_r;
    end
  end

  // Lowest matching index wins; 0 when nothing matches.
  always_comb begin
    idx_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (match_q[i]) idx_c = ADDR_WIDTH'(i);
  end

  // Response beat assembly; all outputs idle outside the response states.
  always_comb begin
    m_tdata = '0;
    if (state == RESP0) begin
      m_tdata[0]               = hit_q;
      m_tdata[1]               = err_len;
      m_tdata[2]               = err_op;
      m_tdata[15:8]            = tag;
      m_tdata[16 +: ADDR_WIDTH] = hit_q ? idx_q : '0;
    end else if (state == RESP1 && hit_q) begin
      m_tdata[DATA_WIDTH-1:0]  = rdata_q;
    end
  end

  assign S_AXIS_TREADY = rst_done && (state == HDR || state == COLLECT || state == DRAIN);
  assign M_AXIS_TVALID = (state == RESP0) || (state == RESP1);
  assign M_AXIS_TLAST  = (state == RESP1);
  assign M_AXIS_TDATA  = m_tdata;
  assign M_AXIS_TSTRB  = '1;
endmodule

// File: doc/tcam_axis_stream.md
Name: tcam_axis_stream

Overview:
- Parametrised successor to the single-entry-request TCAM stream wrapper, with TCAM storage, match logic and AXI4-Stream framing in one single-clock block.
- Accepts command frames on S_AXIS: write, lookup, invalidate and clear-all.
- Returns exactly one 2-beat response frame per command on M_AXIS, with priority-encoded match index, tag echo and frame/opcode error reporting.
- Sits between the stream DMA path and the packet classifier.

Parameters:
- TDATA_WIDTH, 32: S/M_AXIS data width; must be >= 32.
- KEY_WIDTH, 32: key and mask width; must be <= TDATA_WIDTH.
- DATA_WIDTH, 32: per-entry payload width; must be <= TDATA_WIDTH.
- ADDR_WIDTH, 4: entry index width; DEPTH = 2**ADDR_WIDTH; must be <= 8.

Ports:
- ACLK  in  1  sole clock.
- ARESET  in  1  reset, synchronous, active-high.
- S_AXIS_TDATA  in  TDATA_WIDTH  command beats.
- S_AXIS_TSTRB  in  TDATA_WIDTH/8  ignored.
- S_AXIS_TLAST  in  1  command frame end.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TREADY  out  1  beat accepted when TVALID and TREADY are both high.
- M_AXIS_TDATA  out  TDATA_WIDTH  response beats.
- M_AXIS_TSTRB  out  TDATA_WIDTH/8  constant all-ones.
- M_AXIS_TLAST  out  1  high on response beat 1.
- M_AXIS_TVALID  out  1  response valid.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is ACLK, reset port is ARESET.
- Header beat layout:
  - [3:0] opcode: 1 WRITE, 2 LOOKUP, 3 INVALIDATE, 4 CLEAR_ALL.
  - [15:8] tag.
  - [16 +: ADDR_WIDTH] addr.
  - All other bits ignored.
- Frame lengths (beats including header) and contents:
  - WRITE = 4: key, mask, data.
  - LOOKUP = 2: key.
  - INVALIDATE = 1. CLEAR_ALL = 1.
  - Key and mask are taken from TDATA[KEY_WIDTH-1:0]; data from TDATA[DATA_WIDTH-1:0].
- Mask encoding: mask bit 1 = don't care.
- Match rule: entry i matches when valid[i] is set and ((key ^ key_i) & ~mask_i) == 0. When several entries match, the lowest index wins.
- States: HDR, COLLECT, DRAIN, EXEC, ENC, RESP0, RESP1.
- S_AXIS_TREADY is high only in HDR, COLLECT and DRAIN.
- HDR: on an accepted beat, latch opcode, tag and addr.
  - TLAST on a frame of the correct length -> EXEC.
  - TLAST early (WRITE/LOOKUP header) -> EXEC with err_len set, op suppressed.
  - No TLAST on a 1-beat op -> DRAIN with err_len set.
  - No TLAST and opcode unknown -> DRAIN with err_op set.
  - TLAST and opcode unknown -> EXEC with err_op set.
- COLLECT: store beats by index.
  - TLAST before the final beat -> EXEC with err_len.
  - Final beat without TLAST -> DRAIN with err_len.
- DRAIN: discard beats until an accepted beat carries TLAST, then -> EXEC.
- EXEC (1 cycle), only if no error flag is set:
  - WRITE commits key, mask and data to entry addr and sets valid.
  - INVALIDATE clears valid[addr].
  - CLEAR_ALL clears all valid bits.
  - LOOKUP registers the DEPTH-bit match vector.
- ENC (1 cycle): registers hit flag, lowest matching index and that entry's data. For non-lookup ops, hit = 0.
- Latency: last command beat accepted at cycle T -> M_AXIS_TVALID high at T+3 for every opcode and for error frames.
- RESP0 beat: [0] hit, [1] err_len, [2] err_op, [15:8] tag, [16 +: ADDR_WIDTH] match index (0 on miss); all other bits 0.
- RESP1 beat: matched data zero-extended on a hit, else 0. TLAST = 1.
- Backpressure: TDATA, TLAST and TVALID hold stable while TREADY is low. RESP1 accepted -> HDR.
- Ordering: the next command is not accepted until its predecessor's response completes. A lookup following a write therefore always sees the write.
- Reset:
  - TVALID = 0, TREADY = 0, TLAST = 0, TDATA = 0 during reset and on exit.
  - State -> HDR; all valid bits cleared; error flags cleared.
  - Key, mask and data arrays are not reset.
  - Reset mid-frame or mid-response aborts it with no response emitted. The first beat after reset is parsed as a header.
- TSTRB inputs have no effect.

Test Plan:
- WRITE addr 3 key 0xAB0000CD mask 0x00FFFF00 data 0x1234, then LOOKUP 0xAB5566CD tag 0x5A:
  - -> each response is 2 beats, TVALID at T+3.
  - -> lookup status has hit = 1, index 3, tag 0x5A; data beat 0x00001234.
- Entries 2 and 5 both match key 0x11; LOOKUP -> index 2. After INVALIDATE 2, LOOKUP -> index 5. After CLEAR_ALL, LOOKUP -> status hit = 0, data 0.
- LOOKUP with TLAST on the header:
  - -> err_len = 1, hit = 0.
  - -> a following LOOKUP still returns the previous entry contents.
- WRITE frame of 6 beats (no TLAST on beat 3):
  - -> 2 extra beats drained, err_len response.
  - -> entry not written; a subsequent LOOKUP misses.
- Opcode 0x9 single beat -> err_op = 1. Opcode 0x9 with 3 beats -> drained, err_op = 1.
- Hold M_AXIS_TREADY low for 5 cycles on RESP0 -> beat stable and S_AXIS_TREADY low throughout.
- Reset mid-frame or mid-response -> no response emitted; a following LOOKUP misses.
